// File: rtl/hovalaag_io.sv
// Host-side I/O for the Hovalaag CPU: two show-ahead input FIFOs feeding IN1/IN2
// and two output FIFOs capturing OUT, with occupancy counts and sticky error flags.
module hovalaag_io #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  host_wr_valid,
   input  logic                  host_wr_sel,
   input  logic [WIDTH-1:0]      host_wr_data,
   output logic                  host_wr_ready,
   output logic [WIDTH-1:0]      IN1,
   input  logic                  IN1_adv,
   output logic [WIDTH-1:0]      IN2,
   input  logic                  IN2_adv,
   input  logic [WIDTH-1:0]      OUT,
   input  logic                  OUT_valid,
   input  logic                  OUT_select,
   input  logic                  host_rd_sel,
   input  logic                  host_rd_en,
   output logic [WIDTH-1:0]      host_rd_data,
   output logic                  host_rd_valid,
   output logic [DEPTH_LOG2:0]   in1_count,
   output logic [DEPTH_LOG2:0]   in2_count,
   output logic [DEPTH_LOG2:0]   out1_count,
   output logic [DEPTH_LOG2:0]   out2_count,
   output logic [1:0]            err_underrun,
   output logic [1:0]            err_overflow,
   input  logic                  clear_err
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   // FIFO index: 0=IN1, 1=IN2, 2=OUT1, 3=OUT2
   logic [3:0]            push, pop, full, empty;
   logic [WIDTH-1:0]      head [4];
   logic [DEPTH_LOG2:0]   count [4];
   logic [1:0]            underrun_set, overflow_set;
   logic [1:0]            err_underrun_reg, err_overflow_reg;

   always_comb begin
      push         = '0;
      pop          = '0;
      underrun_set = '0;
      overflow_set = '0;
      push[0] = host_wr_valid && !host_wr_sel && !full[0];
      push[1] = host_wr_valid &&  host_wr_sel && !full[1];
      pop[0]  = IN1_adv && !empty[0];
      pop[1]  = IN2_adv && !empty[1];
      underrun_set[0] = IN1_adv && empty[0];
      underrun_set[1] = IN2_adv && empty[1];
      pop[2]  = host_rd_en && !host_rd_sel && !empty[2];
      pop[3]  = host_rd_en &&  host_rd_sel && !empty[3];
      // A capture into a full output FIFO is only safe when the host frees a slot the same cycle
      for (int i = 0; i < 2; i++) begin
         push[2+i]       = OUT_valid && (OUT_select == i[0]) && (!full[2+i] || pop[2+i]);
         overflow_set[i] = OUT_valid && (OUT_select == i[0]) && full[2+i] && !pop[2+i];
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
      logic [WIDTH-1:0]      mem [DEPTH];
      logic [DEPTH_LOG2-1:0] wptr_reg, rptr_reg;
      logic [DEPTH_LOG2:0]   count_reg;
      logic [WIDTH-1:0]      wdata;

      assign wdata = (gi < 2) ? host_wr_data : OUT;

      always_ff @(posedge clk) begin
         if (!rst && push[gi]) begin
            mem[wptr_reg] <= wdata;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
         end else begin
            if (push[gi]) wptr_reg <= wptr_reg + PTR_ONE;
            if (pop[gi])  rptr_reg <= rptr_reg + PTR_ONE;
            case ({push[gi], pop[gi]})
               2'b10:   count_reg <= count_reg + CNT_ONE;
               2'b01:   count_reg <= count_reg - CNT_ONE;
               default: count_reg <= count_reg;
            endcase
         end
      end

      assign count[gi] = count_reg;
      assign full[gi]  = (count_reg == CNT_FULL);
      assign empty[gi] = (count_reg == '0);
      assign head[gi]  = empty[gi] ? '0 : mem[rptr_reg];
   end

   // Set wins over clear so an error in the clearing cycle is never lost
   always_ff @(posedge clk) begin
      if (rst) begin
         err_underrun_reg <= '0;
         err_overflow_reg <= '0;
      end else begin
         err_underrun_reg <= (clear_err ? 2'b00 : err_underrun_reg) | underrun_set;
         err_overflow_reg <= (clear_err ? 2'b00 : err_overflow_reg) | overflow_set;
      end
   end

   assign host_wr_ready = host_wr_sel ? !full[1] : !full[0];
   assign IN1           = head[0];
   assign IN2           = head[1];
   assign host_rd_data  = host_rd_sel ? head[3] : head[2];
   assign host_rd_valid = host_rd_sel ? !empty[3] : !empty[2];
   assign in1_count     = count[0];
   assign in2_count     = count[1];
   assign out1_count    = count[2];
   assign out2_count    = count[3];
   assign err_underrun  = err_underrun_reg;
   assign err_overflow  = err_overflow_reg;
endmodule

// File: tb/tb_hovalaag_io.sv
// Bench for hovalaag_io: directed scenarios plus a randomized run against a queue-based model.
module tb_hovalaag_io;
   localparam int W = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          host_wr_valid, host_wr_sel, host_wr_ready;
   logic [W-1:0]  host_wr_data;
   logic [W-1:0]  IN1, IN2, OUT;
   logic          IN1_adv, IN2_adv, OUT_valid, OUT_select;
   logic          host_rd_sel, host_rd_en, host_rd_valid;
   logic [W-1:0]  host_rd_data;
   logic [4:0]    in1_count, in2_count, out1_count, out2_count;
   logic [1:0]    err_underrun, err_overflow;
   logic          clear_err;

   int checks = 0;
   int errors = 0;

   // Model: 0=IN1, 1=IN2, 2=OUT1, 3=OUT2
   logic [W-1:0] mq [4][$];
   logic [1:0]   m_ur, m_of;

   hovalaag_io #(.DEPTH_LOG2(4), .WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .host_wr_valid(host_wr_valid), .host_wr_sel(host_wr_sel),
      .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
      .IN1(IN1), .IN1_adv(IN1_adv), .IN2(IN2), .IN2_adv(IN2_adv),
      .OUT(OUT), .OUT_valid(OUT_valid), .OUT_select(OUT_select),
      .host_rd_sel(host_rd_sel), .host_rd_en(host_rd_en),
      .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
      .in1_count(in1_count), .in2_count(in2_count),
      .out1_count(out1_count), .out2_count(out2_count),
      .err_underrun(err_underrun), .err_overflow(err_overflow),
      .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      host_wr_valid = 0; host_wr_sel = 0; host_wr_data = '0;
      IN1_adv = 0; IN2_adv = 0;
      OUT = '0; OUT_valid = 0; OUT_select = 0;
      host_rd_sel = 0; host_rd_en = 0; clear_err = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      cycle();
      rst = 0;
   endtask

   task automatic host_push(input logic sel, input logic [W-1:0] d);
      host_wr_valid = 1; host_wr_sel = sel; host_wr_data = d;
      $display("push   in%0d data=%03h", sel + 1, d);
      cycle();
      host_wr_valid = 0;
   endtask

   task automatic out_push(input logic sel, input logic [W-1:0] d);
      OUT_valid = 1; OUT_select = sel; OUT = d;
      $display("cap    out%0d data=%03h", sel + 1, d);
      cycle();
      OUT_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (in1_count !== 0 || in2_count !== 0 || out1_count !== 0 || out2_count !== 0) begin errors++; $display("FAIL reset_counts got %0d %0d %0d %0d exp 0", in1_count, in2_count, out1_count, out2_count); end
      checks++; if (IN1 !== 0 || IN2 !== 0) begin errors++; $display("FAIL reset_heads got %h %h exp 0", IN1, IN2); end
      checks++; if (host_rd_data !== 0 || host_rd_valid !== 0) begin errors++; $display("FAIL reset_rd got %h/%b exp 0/0", host_rd_data, host_rd_valid); end
      checks++; if (host_wr_ready !== 1) begin errors++; $display("FAIL reset_ready got %b exp 1", host_wr_ready); end
      checks++; if (err_underrun !== 0 || err_overflow !== 0) begin errors++; $display("FAIL reset_err got %b %b exp 00 00", err_underrun, err_overflow); end
   endtask

   task automatic test_in1_basic();
      do_reset();
      host_push(0, 12'h123);
      host_push(0, 12'h456);
      checks++; if (IN1 !== 12'h123) begin errors++; $display("FAIL in1_head got %h exp 123", IN1); end
      checks++; if (in1_count !== 2) begin errors++; $display("FAIL in1_count got %0d exp 2", in1_count); end
      IN1_adv = 1; cycle(); IN1_adv = 0;
      checks++; if (IN1 !== 12'h456) begin errors++; $display("FAIL in1_adv1 got %h exp 456", IN1); end
      IN1_adv = 1; cycle(); IN1_adv = 0;
      checks++; if (IN1 !== 0 || in1_count !== 0) begin errors++; $display("FAIL in1_adv2 got %h/%0d exp 0/0", IN1, in1_count); end
      checks++; if (err_underrun !== 0) begin errors++; $display("FAIL in1_noerr got %b exp 00", err_underrun); end
   endtask

   task automatic test_in2_full_wrap();
      logic [W-1:0] vals [16];
      logic [W-1:0] v;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         vals[i] = W'($urandom);
         host_push(1, vals[i]);
      end
      host_wr_sel = 1;
      #1;
      checks++; if (host_wr_ready !== 0 || in2_count !== 16) begin errors++; $display("FAIL in2_full got ready=%b cnt=%0d exp 0/16", host_wr_ready, in2_count); end
      host_push(1, 12'hEEE);
      checks++; if (in2_count !== 16) begin errors++; $display("FAIL in2_drop got %0d exp 16", in2_count); end
      IN2_adv = 1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (IN2 !== vals[i]) begin errors++; $display("FAIL in2_order[%0d] got %h exp %h", i, IN2, vals[i]); end
         cycle();
      end
      IN2_adv = 0;
      checks++; if (in2_count !== 0 || IN2 !== 0) begin errors++; $display("FAIL in2_drained got %0d/%h exp 0/0", in2_count, IN2); end
      for (int k = 0; k < 5; k++) begin
         v = W'($urandom);
         host_push(1, v);
         checks++; if (IN2 !== v) begin errors++; $display("FAIL in2_wrap[%0d] got %h exp %h", k, IN2, v); end
         IN2_adv = 1; cycle(); IN2_adv = 0;
         checks++; if (in2_count !== 0) begin errors++; $display("FAIL in2_wrap_cnt[%0d] got %0d exp 0", k, in2_count); end
      end
   endtask

   task automatic test_underrun();
      do_reset();
      IN1_adv = 1; cycle(); IN1_adv = 0;
      checks++; if (err_underrun !== 2'b01) begin errors++; $display("FAIL underrun_set got %b exp 01", err_underrun); end
      IN1_adv = 1; clear_err = 1; cycle(); IN1_adv = 0; clear_err = 0;
      checks++; if (err_underrun !== 2'b01) begin errors++; $display("FAIL underrun_setwins got %b exp 01", err_underrun); end
      clear_err = 1; cycle(); clear_err = 0;
      checks++; if (err_underrun !== 2'b00) begin errors++; $display("FAIL underrun_clear got %b exp 00", err_underrun); end
   endtask

   task automatic test_out_capture();
      do_reset();
      out_push(0, 12'hABC);
      out_push(1, 12'h0FF);
      checks++; if (out1_count !== 1 || out2_count !== 1) begin errors++; $display("FAIL out_counts got %0d %0d exp 1 1", out1_count, out2_count); end
      host_rd_sel = 1; #1;
      checks++; if (host_rd_data !== 12'h0FF || host_rd_valid !== 1) begin errors++; $display("FAIL out2_head got %h/%b exp 0ff/1", host_rd_data, host_rd_valid); end
      host_rd_sel = 0; #1;
      checks++; if (host_rd_data !== 12'hABC || host_rd_valid !== 1) begin errors++; $display("FAIL out1_head got %h/%b exp abc/1", host_rd_data, host_rd_valid); end
      host_rd_en = 1; cycle(); host_rd_en = 0;
      checks++; if (out1_count !== 0 || out2_count !== 1 || host_rd_valid !== 0) begin errors++; $display("FAIL out_read got %0d %0d %b exp 0 1 0", out1_count, out2_count, host_rd_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) out_push(0, W'(i));
      checks++; if (out1_count !== 16) begin errors++; $display("FAIL ovf_fill got %0d exp 16", out1_count); end
      out_push(0, 12'h999);
      checks++; if (err_overflow !== 2'b01 || out1_count !== 16) begin errors++; $display("FAIL ovf_set got %b/%0d exp 01/16", err_overflow, out1_count); end
      clear_err = 1; cycle(); clear_err = 0;
      checks++; if (err_overflow !== 2'b00) begin errors++; $display("FAIL ovf_clear got %b exp 00", err_overflow); end
      host_rd_sel = 0; host_rd_en = 1;
      out_push(0, 12'h777);
      host_rd_en = 0;
      checks++; if (err_overflow !== 2'b00 || out1_count !== 16) begin errors++; $display("FAIL ovf_pop_same got %b/%0d exp 00/16", err_overflow, out1_count); end
      for (int i = 1; i <= 16; i++) begin
         logic [W-1:0] e;
         e = (i < 16) ? W'(i) : 12'h777;
         checks++; if (host_rd_data !== e) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, host_rd_data, e); end
         host_rd_en = 1; cycle(); host_rd_en = 0;
      end
      checks++; if (out1_count !== 0 || host_rd_valid !== 0) begin errors++; $display("FAIL ovf_empty got %0d/%b exp 0/0", out1_count, host_rd_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      host_wr_valid = 1; host_wr_sel = 0; host_wr_data = 12'h055; IN1_adv = 1;
      cycle(); idle();
      checks++; if (in1_count !== 1 || err_underrun !== 2'b01 || IN1 !== 12'h055) begin errors++; $display("FAIL b2b_empty got %0d/%b/%h exp 1/01/055", in1_count, err_underrun, IN1); end
      host_wr_valid = 1; host_wr_data = 12'h066; IN1_adv = 1;
      cycle(); idle();
      checks++; if (in1_count !== 1 || IN1 !== 12'h066) begin errors++; $display("FAIL b2b_nonempty got %0d/%h exp 1/066", in1_count, IN1); end
      for (int i = 0; i < 15; i++) host_push(0, W'(i + 1));
      host_wr_valid = 1; host_wr_data = 12'hDDD; IN1_adv = 1;
      cycle(); idle();
      checks++; if (in1_count !== 15 || host_wr_ready !== 1 || IN1 !== 12'h001) begin errors++; $display("FAIL b2b_full got %0d/%b/%h exp 15/1/001", in1_count, host_wr_ready, IN1); end
   endtask

   task automatic test_random(input int n);
      int sz [4];
      logic [1:0] new_ur, new_of;
      logic rdpop;
      logic [W-1:0] e1, e2, erd;
      do_reset();
      for (int f = 0; f < 4; f++) mq[f].delete();
      m_ur = 0; m_of = 0;
      for (int c = 0; c < n; c++) begin
         host_wr_valid = ($urandom_range(0, 9) < 6);
         host_wr_sel   = 1'($urandom_range(0, 1));
         host_wr_data  = W'($urandom);
         IN1_adv       = ($urandom_range(0, 9) < 3);
         IN2_adv       = ($urandom_range(0, 9) < 3);
         OUT_valid     = ($urandom_range(0, 9) < 6);
         OUT_select    = 1'($urandom_range(0, 1));
         OUT           = W'($urandom);
         host_rd_en    = ($urandom_range(0, 9) < 3);
         host_rd_sel   = 1'($urandom_range(0, 1));
         clear_err     = ($urandom_range(0, 19) == 0);
         #1;
         for (int f = 0; f < 4; f++) sz[f] = mq[f].size();
         e1  = (sz[0] > 0) ? mq[0][0] : '0;
         e2  = (sz[1] > 0) ? mq[1][0] : '0;
         erd = (sz[2 + host_rd_sel] > 0) ? mq[2 + host_rd_sel][0] : '0;
         checks++; if (IN1 !== e1 || IN2 !== e2) begin errors++; $display("FAIL rnd_heads[%0d] got %h %h exp %h %h", c, IN1, IN2, e1, e2); end
         checks++; if (host_wr_ready !== (sz[host_wr_sel] < 16)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", c, host_wr_ready, sz[host_wr_sel] < 16); end
         checks++; if (host_rd_data !== erd || host_rd_valid !== (sz[2 + host_rd_sel] > 0)) begin errors++; $display("FAIL rnd_rd[%0d] got %h/%b exp %h/%b", c, host_rd_data, host_rd_valid, erd, sz[2 + host_rd_sel] > 0); end
         new_ur = 0; new_of = 0;
         if (host_wr_valid && sz[host_wr_sel] < 16) mq[host_wr_sel].push_back(host_wr_data);
         if (IN1_adv) begin if (sz[0] > 0) void'(mq[0].pop_front()); else new_ur[0] = 1; end
         if (IN2_adv) begin if (sz[1] > 0) void'(mq[1].pop_front()); else new_ur[1] = 1; end
         rdpop = host_rd_en && sz[2 + host_rd_sel] > 0;
         if (rdpop) void'(mq[2 + host_rd_sel].pop_front());
         if (OUT_valid) begin
            if (sz[2 + OUT_select] < 16 || (rdpop && host_rd_sel == OUT_select)) mq[2 + OUT_select].push_back(OUT);
            else new_of[OUT_select] = 1;
         end
         m_ur = (clear_err ? 2'b00 : m_ur) | new_ur;
         m_of = (clear_err ? 2'b00 : m_of) | new_of;
         cycle();
         checks++; if (in1_count !== mq[0].size() || in2_count !== mq[1].size() || out1_count !== mq[2].size() || out2_count !== mq[3].size()) begin errors++; $display("FAIL rnd_counts[%0d] got %0d %0d %0d %0d exp %0d %0d %0d %0d", c, in1_count, in2_count, out1_count, out2_count, mq[0].size(), mq[1].size(), mq[2].size(), mq[3].size()); end
         checks++; if (err_underrun !== m_ur || err_overflow !== m_of) begin errors++; $display("FAIL rnd_err[%0d] got %b %b exp %b %b", c, err_underrun, err_overflow, m_ur, m_of); end
      end
      idle();
   endtask

   task automatic test_rst_midstream();
      do_reset();
      IN1_adv = 1; cycle(); IN1_adv = 0;
      for (int i = 0; i < 3; i++) host_push(0, W'(i + 7));
      for (int i = 0; i < 2; i++) host_push(1, W'(i + 9));
      out_push(0, 12'h111);
      out_push(1, 12'h222);
      checks++; if (in1_count !== 3 || err_underrun !== 2'b01) begin errors++; $display("FAIL rst_pre got %0d/%b exp 3/01", in1_count, err_underrun); end
      rst = 1; host_wr_valid = 1; host_wr_data = 12'h3AB; OUT_valid = 1; OUT = 12'h4CD; IN2_adv = 1;
      cycle();
      rst = 0; idle();
      #1;
      checks++; if (in1_count !== 0 || in2_count !== 0 || out1_count !== 0 || out2_count !== 0) begin errors++; $display("FAIL rst_counts got %0d %0d %0d %0d exp 0", in1_count, in2_count, out1_count, out2_count); end
      checks++; if (IN1 !== 0 || IN2 !== 0 || host_rd_valid !== 0) begin errors++; $display("FAIL rst_heads got %h %h %b exp 0 0 0", IN1, IN2, host_rd_valid); end
      host_rd_sel = 1; #1;
      checks++; if (host_rd_valid !== 0 || host_rd_data !== 0) begin errors++; $display("FAIL rst_out2 got %b/%h exp 0/0", host_rd_valid, host_rd_data); end
      checks++; if (err_underrun !== 0 || err_overflow !== 0) begin errors++; $display("FAIL rst_err got %b %b exp 00 00", err_underrun, err_overflow); end
   endtask

   initial begin
      rst = 1;
      idle();
      test_reset();
      test_in1_basic();
      test_in2_full_wrap();
      test_underrun();
      test_out_capture();
      test_overflow();
      test_back_to_back();
      test_random(600);
      test_rst_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hovalaag_io.md
Name: hovalaag_io

Overview:
- Host-side I/O subsystem that sits at the other end of the Hovalaag CPU's IN1/IN2 and OUT interfaces.
- Input side: two show-ahead FIFOs, loaded by the host, present values on IN1/IN2 and pop on the CPU's IN1_adv/IN2_adv.
- Output side: captures OUT words into two output FIFOs, steered by OUT_select, for the host to drain.
- Provides occupancy counts and sticky underrun/overflow error flags for test harnesses.

Parameters:
- DEPTH_LOG2, 4, log2 of entries per FIFO (16 entries each, all four FIFOs).
- WIDTH, 12, data width; matches the CPU word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- host_wr_valid  in  1  host push request to an input FIFO.
- host_wr_sel  in  1  target: 0=IN1 FIFO, 1=IN2 FIFO.
- host_wr_data  in  WIDTH  push data.
- host_wr_ready  out  1  selected input FIFO not full (combinational on host_wr_sel).
- IN1  out  WIDTH  head of IN1 FIFO; 0 when empty.
- IN1_adv  in  1  CPU consumed IN1; pop.
- IN2  out  WIDTH  head of IN2 FIFO; 0 when empty.
- IN2_adv  in  1  CPU consumed IN2; pop.
- OUT  in  WIDTH  CPU output word.
- OUT_valid  in  1  OUT is valid this cycle.
- OUT_select  in  1  0=OUT1 FIFO, 1=OUT2 FIFO.
- host_rd_sel  in  1  output FIFO select: 0=OUT1, 1=OUT2.
- host_rd_en  in  1  pop the selected output FIFO.
- host_rd_data  out  WIDTH  head of selected output FIFO; 0 when empty.
- host_rd_valid  out  1  selected output FIFO non-empty.
- in1_count, in2_count, out1_count, out2_count  out  DEPTH_LOG2+1 each  occupancy, range 0..2^DEPTH_LOG2.
- err_underrun  out  2  sticky; bit0=IN1, bit1=IN2.
- err_overflow  out  2  sticky; bit0=OUT1, bit1=OUT2.
- clear_err  in  1  clears all sticky error bits.

Behaviour:
- Reset: all read/write pointers, counts and error bits go to 0. IN1, IN2 and host_rd_data are 0; host_rd_valid is 0; host_wr_ready is 1. An asserted rst discards all FIFO contents, even mid-operation, and overrides every other input that cycle.
- FIFOs:
  - Circular buffers with a DEPTH_LOG2-bit address; pointers wrap modulo depth.
  - Full is count == 2^DEPTH_LOG2; empty is count == 0.
  - Storage is registered. The head output is a combinational read of storage at the read pointer, gated to 0 when empty.
- Input push: on host_wr_valid && host_wr_ready, the data is written at the tail. It is visible on IN1/IN2 the next cycle if the FIFO was empty. A push when full is dropped silently, with no flag.
- Input pop: on INx_adv with the FIFO non-empty, the read pointer advances at the clock edge. The next value appears the following cycle, so the CPU consuming every cycle sees consecutive entries.
- INx_adv while empty: no pointer change; err_underrun[x] is set.
- Simultaneous push and pop on the same FIFO:
  - Non-empty: both occur and count is unchanged.
  - Empty: the push occurs, the pop is an underrun, and count becomes 1.
  - Full: the pop occurs, the push is dropped (host_wr_ready was 0), and count becomes depth−1.
- Output capture: when OUT_valid is 1, OUT is pushed into the FIFO chosen by OUT_select, in the same cycle with no added latency.
- OUT_valid with the target FIFO full: the word is dropped and err_overflow[sel] is set, unless a host pop of that FIFO occurs in the same cycle. In that case both occur and there is no error.
- Host read: host_rd_en with the selected FIFO non-empty pops it. host_rd_en on an empty FIFO has no effect and no error. A capture and a host pop on the same output FIFO in one cycle both occur.
- Error bits: once set they stay set until clear_err or rst. If clear_err and a new error event occur in the same cycle, the set wins.
- IN1 and IN2 are independent; the CPU raises at most one adv per cycle, but both must work if asserted together.
- Counts update at the clock edge, reflecting push/pop: +1, −1, or 0 when both or neither occur.

Test Plan:
- Reset, then push 0x123, 0x456 to IN1 → IN1=0x123 and in1_count=2. Pulse IN1_adv → next cycle IN1=0x456; pulse again → IN1=0, count=0.
- Push 16 words to IN2 → host_wr_ready=0 and in2_count=16. A 17th push is dropped; pop 16 → values in order, and pointer wrap is exercised by a further 5 push/pop pairs.
- IN1_adv with IN1 empty → err_underrun=2'b01. Assert clear_err together with a second empty IN1_adv → bit remains 1; clear_err alone → 0.
- OUT_valid with OUT=0xABC, OUT_select=0, then OUT=0x0FF, OUT_select=1 → out1_count=1 and out2_count=1. host_rd_sel=1 gives host_rd_data=0x0FF; host_rd_sel=0 gives 0xABC.
- Fill OUT1 to 16, then OUT_valid to OUT1 → err_overflow=2'b01, count stays 16. Repeat with host_rd_en on OUT1 in the same cycle → no error, count stays 16, new word at the tail.
- Assert rst mid-stream with all FIFOs partly full → next cycle all counts=0, IN1=IN2=0, host_rd_valid=0, errors cleared.
